percent_display: RTL and testbench



---
 rtl/percent_display_pkg.sv | 56 +++++
 rtl/percent_display_bcd_to_seg.sv | 24 ++
 rtl/percent_display.sv | 156 +++++++++++++++
 tb/tb_percent_display.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/percent_display_pkg.sv
// Shared definitions for the percent display path: FSM encoding, widths,
// clamp default, active-high seven-segment patterns and the double-dabble
// nibble adjustment.
package percent_display_pkg;

    localparam int unsigned PCT_W           = 7;
    localparam int unsigned BCD_W           = 12;
    localparam int unsigned CNT_W           = 3;
    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned SEG_W           = 7;
    localparam int unsigned PERCENT_MAX_DEF = 100;

    // Counter value of the final (7th) shift iteration.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(6);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

    // Active-high pattern for a BCD digit; non-decimal codes go blank.
    function automatic logic [SEG_W-1:0] digit_pattern(input logic [DIGIT_W-1:0] d);
        if (d <= DIGIT_W'(9)) begin
            return SEG_DIGIT[d];
        end
        return SEG_BLANK;
    endfunction

    // Add 3 to every nibble >= 5, independently (no inter-nibble carry).
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/percent_display_bcd_to_seg.sv
// BCD digit to seven-segment pattern with blanking and selectable polarity.
// Ports:
//   digit      - BCD digit (codes 10..15 decode to blank)
//   blank      - force all segments off
//   active_low - 1: invert pattern for active-low displays
//   seg_c      - combinational pattern, bit order {g,f,e,d,c,b,a}
module bcd_to_seg
    import percent_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    input  logic               active_low,
    output logic [SEG_W-1:0]   seg_c
);

    logic [SEG_W-1:0] pattern_c;

    // Blank means "all off" at the configured polarity.
    always_comb begin
        pattern_c = blank ? SEG_BLANK : digit_pattern(digit);
        seg_c     = active_low ? ~pattern_c : pattern_c;
    end

endmodule

// File: rtl/percent_display.sv
// Percent-lost display: sequential double-dabble conversion of a 7-bit value
// into three BCD digits plus seven-segment drive with leading-zero blanking.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start                 - conversion request (IDLE only)
//   percent_in            - value 0..100; larger codes clamp and flag
//   busy                  - high while shifting
//   done                  - one-cycle pulse when new digits are valid
//   over_range            - last converted input exceeded PERCENT_MAX
//   bcd_hundreds/tens/ones- registered BCD digits
//   seg_hundreds/tens/ones- segment patterns decoded from the BCD digits
module percent_display
    import percent_display_pkg::*;
#(
    parameter bit          AUTO_UPDATE    = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned PERCENT_MAX    = PERCENT_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PCT_W-1:0]   percent_in,
    output logic               busy,
    output logic               done,
    output logic               over_range,
    output logic [DIGIT_W-1:0] bcd_hundreds,
    output logic [DIGIT_W-1:0] bcd_tens,
    output logic [DIGIT_W-1:0] bcd_ones,
    output logic [SEG_W-1:0]   seg_hundreds,
    output logic [SEG_W-1:0]   seg_tens,
    output logic [SEG_W-1:0]   seg_ones
);

    state_e               state_q,      state_d;
    logic [PCT_W-1:0]     operand_q,    operand_d;
    logic [BCD_W-1:0]     scratch_q,    scratch_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic                 ovr_q,        ovr_d;
    logic [PCT_W-1:0]     last_q,       last_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 over_range_q, over_range_d;
    logic [BCD_W-1:0]     bcd_q,        bcd_d;

    logic                 trigger_c;
    logic                 over_c;
    logic [BCD_W-1:0]     adj_c;
    logic [BCD_W+PCT_W-1:0] shift_c;

    // Next-state and datapath for the IDLE/SHIFT conversion FSM.
    always_comb begin
        state_d      = state_q;
        operand_d    = operand_q;
        scratch_d    = scratch_q;
        cnt_d        = cnt_q;
        ovr_d        = ovr_q;
        last_d       = last_q;
        done_d       = 1'b0;
        over_range_d = over_range_q;
        bcd_d        = bcd_q;

        trigger_c = start || (AUTO_UPDATE && (percent_in != last_q));
        over_c    = 32'(percent_in) > PERCENT_MAX;
        adj_c     = bcd_add3(scratch_q);
        shift_c   = {adj_c, operand_q} << 1;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger_c) begin
                    operand_d = over_c ? PCT_W'(PERCENT_MAX) : percent_in;
                    ovr_d     = over_c;
                    last_d    = percent_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = shift_c[BCD_W+PCT_W-1:PCT_W];
                operand_d = shift_c[PCT_W-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    bcd_d        = shift_c[BCD_W+PCT_W-1:PCT_W];
                    over_range_d = ovr_q;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            operand_q    <= '0;
            scratch_q    <= '0;
            cnt_q        <= '0;
            ovr_q        <= 1'b0;
            last_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            over_range_q <= 1'b0;
            bcd_q        <= '0;
        end else begin
            state_q      <= state_d;
            operand_q    <= operand_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            ovr_q        <= ovr_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            over_range_q <= over_range_d;
            bcd_q        <= bcd_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign over_range   = over_range_q;
    assign bcd_hundreds = bcd_q[11:8];
    assign bcd_tens     = bcd_q[7:4];
    assign bcd_ones     = bcd_q[3:0];

    // Leading-zero blanking: tens only shows a zero when hundreds is lit.
    logic blank_h_c;
    logic blank_t_c;
    assign blank_h_c = (bcd_q[11:8] == 4'd0);
    assign blank_t_c = blank_h_c && (bcd_q[7:4] == 4'd0);

    bcd_to_seg u_seg_hundreds (
        .digit      (bcd_q[11:8]),
        .blank      (blank_h_c),
        .active_low (SEG_ACTIVE_LOW),
        .seg_c      (seg_hundreds)
    );

    bcd_to_seg u_seg_tens (
        .digit      (bcd_q[7:4]),
        .blank      (blank_t_c),
        .active_low (SEG_ACTIVE_LOW),
        .seg_c      (seg_tens)
    );

    bcd_to_seg u_seg_ones (
        .digit      (bcd_q[3:0]),
        .blank      (1'b0),
        .active_low (SEG_ACTIVE_LOW),
        .seg_c      (seg_ones)
    );

endmodule

// File: tb/tb_percent_display.sv
// Self-checking bench for percent_display: a cycle-level behavioural model
// (countdown + integer division) checked every cycle, plus literal checks.
module tb_percent_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset  = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [6:0] pin0   = 7'd0;
    logic [6:0] pin1   = 7'd0;

    logic       busy0, done0, ovr0, busy1, done1, ovr1;
    logic [3:0] h0, t0, o0, h1, t1, o1;
    logic [6:0] sh0, st0, so0, sh1, st1, so1;

    percent_display #(.AUTO_UPDATE(1'b0), .SEG_ACTIVE_LOW(1'b1), .PERCENT_MAX(100)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .percent_in(pin0),
        .busy(busy0), .done(done0), .over_range(ovr0),
        .bcd_hundreds(h0), .bcd_tens(t0), .bcd_ones(o0),
        .seg_hundreds(sh0), .seg_tens(st0), .seg_ones(so0)
    );

    percent_display #(.AUTO_UPDATE(1'b1), .SEG_ACTIVE_LOW(1'b0), .PERCENT_MAX(100)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .percent_in(pin1),
        .busy(busy1), .done(done1), .over_range(ovr1),
        .bcd_hundreds(h1), .bcd_tens(t1), .bcd_ones(o1),
        .seg_hundreds(sh1), .seg_tens(st1), .seg_ones(so1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int left;      // busy cycles still to come
        int pend;      // clamped value in flight
        bit pend_ovr;
        int shown;     // value currently on the outputs
        bit ovr;
        bit done;
        int last;      // raw value of the last accepted request
    } model_t;

    model_t m0, m1;
    bit model_ok = 1'b0;

    function automatic model_t step(input model_t m, input bit rst, input bit st,
                                    input int pin, input bit auto_up);
        model_t r;
        r = m;
        if (rst) begin
            r.left = 0; r.pend = 0; r.pend_ovr = 0; r.shown = 0;
            r.ovr = 0; r.done = 0; r.last = 0;
            return r;
        end
        r.done = 0;
        if (r.left > 0) begin
            r.left--;
            if (r.left == 0) begin
                r.shown = r.pend;
                r.ovr   = r.pend_ovr;
                r.done  = 1;
            end
        end else if (st || (auto_up && pin != r.last)) begin
            r.left     = 7;
            r.pend     = (pin > 100) ? 100 : pin;
            r.pend_ovr = (pin > 100);
            r.last     = pin;
        end
        return r;
    endfunction

    function automatic logic [6:0] dig_pat(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // pos: 2 = hundreds, 1 = tens, 0 = ones
    function automatic logic [6:0] exp_seg(input int val, input int pos, input bit al);
        int h, t, o, d;
        bit blank;
        logic [6:0] p;
        h = val / 100; t = (val / 10) % 10; o = val % 10;
        if (pos == 2)      begin d = h; blank = (h == 0); end
        else if (pos == 1) begin d = t; blank = (h == 0) && (t == 0); end
        else               begin d = o; blank = 0; end
        p = blank ? 7'b0000000 : dig_pat(d);
        return al ? ~p : p;
    endfunction

    task automatic cmp(input string tag, input model_t m, input bit al,
                       input logic b, input logic d, input logic ov,
                       input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic [6:0] sh, input logic [6:0] stn, input logic [6:0] so);
        chk({tag, ".busy"},       int'(b),  int'(m.left > 0));
        chk({tag, ".done"},       int'(d),  int'(m.done));
        chk({tag, ".over_range"}, int'(ov), int'(m.ovr));
        chk({tag, ".bcd_h"},      int'(h),  m.shown / 100);
        chk({tag, ".bcd_t"},      int'(t),  (m.shown / 10) % 10);
        chk({tag, ".bcd_o"},      int'(o),  m.shown % 10);
        chk({tag, ".seg_h"},      int'(sh), int'(exp_seg(m.shown, 2, al)));
        chk({tag, ".seg_t"},      int'(stn), int'(exp_seg(m.shown, 1, al)));
        chk({tag, ".seg_o"},      int'(so), int'(exp_seg(m.shown, 0, al)));
    endtask

    always @(posedge clk) begin
        m0 = step(m0, reset, start0, int'(pin0), 1'b0);
        m1 = step(m1, reset, start1, int'(pin1), 1'b1);
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            cmp("dut0", m0, 1'b1, busy0, done0, ovr0, h0, t0, o0, sh0, st0, so0);
            cmp("dut1", m1, 1'b0, busy1, done1, ovr1, h1, t1, o1, sh1, st1, so1);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv0(input int val, input int eh, input int et, input int eo, input int eovr,
                         input logic [6:0] esh, input logic [6:0] est, input logic [6:0] eso);
        int lat, nb;
        bit got;
        pin0 = 7'(val); start0 = 1'b1;
        tick();
        start0 = 1'b0;
        lat = 1; nb = 0; got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done0) begin got = 1; break; end
            if (busy0) nb++;
            tick();
            lat++;
        end
        chk($sformatf("conv%0d.done_seen", val), int'(got), 1);
        chk($sformatf("conv%0d.latency", val), lat, 8);
        chk($sformatf("conv%0d.busy_cycles", val), nb, 7);
        if (got) begin
            chk($sformatf("conv%0d.h", val), int'(h0), eh);
            chk($sformatf("conv%0d.t", val), int'(t0), et);
            chk($sformatf("conv%0d.o", val), int'(o0), eo);
            chk($sformatf("conv%0d.ovr", val), int'(ovr0), eovr);
            chk($sformatf("conv%0d.seg_h", val), int'(sh0), int'(esh));
            chk($sformatf("conv%0d.seg_t", val), int'(st0), int'(est));
            chk($sformatf("conv%0d.seg_o", val), int'(so0), int'(eso));
        end
    endtask

    initial begin
        int nd, lat;
        bit got;
        int pick;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst.bcd", int'({h0, t0, o0}), 0);
        chk("rst.seg_o", int'(so0), int'(7'b1000000));
        chk("rst.seg_t", int'(st0), int'(7'b1111111));
        chk("rst.seg_h", int'(sh0), int'(7'b1111111));
        chk("rst.busy_done", int'({busy0, done0}), 0);
        chk("rst1.seg_o", int'(so1), int'(7'b0111111));
        chk("rst1.seg_th", int'({st1, sh1}), 0);
        tick();

        conv0(37,  0, 3, 7, 0, 7'b1111111, 7'b0110000, 7'b1111000);
        conv0(100, 1, 0, 0, 0, 7'b1111001, 7'b1000000, 7'b1000000);
        conv0(117, 1, 0, 0, 1, 7'b1111001, 7'b1000000, 7'b1000000);
        conv0(5,   0, 0, 5, 0, 7'b1111111, 7'b1111111, 7'b0010010);
        tick();

        // start while busy is ignored
        pin0 = 7'd42; start0 = 1'b1;
        tick();                              // cycle N+1
        start0 = 1'b0;
        tick(); tick();                      // cycle N+3
        pin0 = 7'd9; start0 = 1'b1;
        tick();                              // cycle N+4
        start0 = 1'b0;
        nd = 0;
        for (int k = 4; k < 16; k++) begin
            @(negedge clk);
            if (done0) begin
                nd++;
                chk("ignore.done_cycle", k, 8);
                chk("ignore.bcd", int'({h0, t0, o0}), int'(12'h042));
            end
            tick();
        end
        chk("ignore.done_count", nd, 1);

        // reset mid-conversion discards it
        pin0 = 7'd88; start0 = 1'b1;
        tick();                              // N+1
        start0 = 1'b0;
        repeat (3) tick();                   // N+4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.bcd", int'({h0, t0, o0}), 0);
        chk("midrst.seg_o", int'(so0), int'(7'b1000000));
        chk("midrst.seg_t", int'(st0), int'(7'b1111111));
        chk("midrst.busy", int'(busy0), 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            @(negedge clk);
            if (done0) nd++;
        end
        chk("midrst.no_done", nd, 0);
        tick();

        // auto update on dut1 (active-high segments)
        pin1 = 7'd64;
        tick();
        lat = 1; got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done1) begin got = 1; break; end
            tick();
            lat++;
        end
        chk("auto.done_seen", int'(got), 1);
        chk("auto.latency", lat, 8);
        chk("auto.bcd", int'({h1, t1, o1}), int'(12'h064));
        chk("auto.seg_t", int'(st1), int'(7'b1111101));
        chk("auto.seg_o", int'(so1), int'(7'b1100110));
        chk("auto.seg_h", int'(sh1), 0);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            @(negedge clk);
            if (done1) nd++;
        end
        chk("auto.hold_no_done", nd, 0);
        tick();

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            start0 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                pick = $urandom_range(0, 9);
                case (pick)
                    0: pin0 = 7'd0;
                    1: pin0 = 7'd99;
                    2: pin0 = 7'd100;
                    3: pin0 = 7'd101;
                    4: pin0 = 7'd127;
                    default: pin0 = 7'($urandom_range(0, 127));
                endcase
            end
            start1 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) pin1 = 7'($urandom_range(0, 127));
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
